// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing one single-port grid BRAM between the scatterer, solver and pusher.
// Registers the winning access onto the BRAM port and steers read data back to the issuing requester.
module grid_port_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           phase_mask,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [DATA_W-1:0]          rd_data,
  output logic [N_REQ-1:0]           rd_valid,
  output logic                       idle,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_next;
  logic [N_REQ-1:0]  elig;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [N_REQ-1:0]  tag [0:READ_LAT];
  logic              busy;

  // Priority rank k maps to requester i where i == (ptr + k) mod N_REQ.
  always_comb begin
    elig      = req & phase_mask & {N_REQ{~rst}};
    gnt       = '0;
    accept    = 1'b0;
    ptr_next  = ptr;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!accept && elig[i] && (ptr == PW'((i + N_REQ - k) % N_REQ))) begin
          gnt[i]    = 1'b1;
          accept    = 1'b1;
          ptr_next  = PW'((i + 1) % N_REQ);
          win_we    = req_we[i];
          win_addr  = req_addr[i*ADDR_W +: ADDR_W];
          win_wdata = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      for (int unsigned k = 0; k <= READ_LAT; k++) begin
        tag[k] <= '0;
      end
    end else begin
      ptr    <= ptr_next;
      mem_en <= accept;
      mem_we <= accept & win_we;
      if (accept) begin
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
      end
      tag[0] <= (accept && !win_we) ? gnt : '0;
      for (int unsigned k = 1; k <= READ_LAT; k++) begin
        tag[k] <= tag[k-1];
      end
      // Capture BRAM output one stage before the tag reaches rd_valid.
      if (|tag[READ_LAT-1]) begin
        rd_data <= mem_rdata;
      end
    end
  end

  assign rd_valid = tag[READ_LAT];

  always_comb begin
    busy = mem_en;
    for (int unsigned k = 0; k <= READ_LAT; k++) begin
      busy = busy | (|tag[k]);
    end
    idle = ~busy;
  end

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Scoreboard bench for grid_port_arbiter: directed vectors push expected grants, BRAM issues and
// read returns (with their cycle numbers); a monitor pops and compares whenever the DUT presents them.
module tb_grid_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  phase_mask, req, req_we;
  logic [35:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  gnt, rd_valid;
  logic [31:0] rd_data, mem_wdata, mem_rdata;
  logic        idle, mem_en, mem_we;
  logic [11:0] mem_addr;

  logic [11:0] ra [3];
  logic [31:0] rw [3];
  assign req_addr  = {ra[2], ra[1], ra[0]};
  assign req_wdata = {rw[2], rw[1], rw[0]};

  grid_port_arbiter #(.N_REQ(3), .ADDR_W(12), .DATA_W(32), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .phase_mask(phase_mask), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .idle(idle), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: one-cycle registered read; the arbiter's capture register adds the second cycle.
  function automatic logic [31:0] pre(input logic [11:0] a);
    return (a == 12'h005) ? 32'hDEAD_BEEF : (32'hA500_0000 | {20'h0, a});
  endfunction

  logic [31:0] wmem [0:4095];
  bit          wflag [0:4095];
  logic [31:0] q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wmem[mem_addr]  <= mem_wdata;
        wflag[mem_addr] <= 1'b1;
      end else begin
        q <= wflag[mem_addr] ? wmem[mem_addr] : pre(mem_addr);
      end
    end
  end
  assign mem_rdata = q;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  sel;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t iq[$];
  exp_t rq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (gnt != 3'b000) begin
        if (gq.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'h0);
        else begin
          e = gq.pop_front();
          chk("gnt", 64'(gnt), 64'(e.sel));
          chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (mem_en) begin
        if (iq.size() == 0) chk("unexpected_mem_en", 64'(mem_en), 64'h0);
        else begin
          e = iq.pop_front();
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (rd_valid != 3'b000) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", 64'(rd_valid), 64'h0);
        else begin
          e = rq.pop_front();
          chk("rd_valid", 64'(rd_valid), 64'(e.sel));
          chk("rd_data", 64'(rd_data), 64'(e.data));
          chk("rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int unsigned i, input logic [11:0] a, input logic [31:0] d,
                         input int unsigned t);
    gq.push_back('{t, 3'b001 << i, 1'b0, a, 32'h0});
    iq.push_back('{t + 1, 3'b001 << i, 1'b0, a, 32'h0});
    rq.push_back('{t + 3, 3'b001 << i, 1'b0, a, d});
  endtask

  task automatic push_wr(input int unsigned i, input logic [11:0] a, input logic [31:0] d,
                         input int unsigned t);
    gq.push_back('{t, 3'b001 << i, 1'b1, a, 32'h0});
    iq.push_back('{t + 1, 3'b001 << i, 1'b1, a, d});
  endtask

  task automatic check_drained(input string name);
    chk({name, "_gq_empty"}, 64'(gq.size()), 64'h0);
    chk({name, "_iq_empty"}, 64'(iq.size()), 64'h0);
    chk({name, "_rq_empty"}, 64'(rq.size()), 64'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_gnt"}, 64'(gnt), 64'h0);
    chk({name, "_rd_valid"}, 64'(rd_valid), 64'h0);
    chk({name, "_rd_data"}, 64'(rd_data), 64'h0);
    chk({name, "_mem_en"}, 64'(mem_en), 64'h0);
    chk({name, "_mem_we"}, 64'(mem_we), 64'h0);
    chk({name, "_mem_addr"}, 64'(mem_addr), 64'h0);
    chk({name, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
    chk({name, "_idle"}, 64'(idle), 64'h1);
  endtask

  task automatic idle_inputs();
    req = 3'b000; req_we = 3'b000;
    for (int i = 0; i < 3; i++) begin ra[i] = 12'h0; rw[i] = 32'h0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    int unsigned cnt [3];
    int unsigned w;
    logic [11:0] a;

    // Reset state, with requests asserted to confirm grants are suppressed in reset.
    rst = 1'b1; phase_mask = 3'b111; idle_inputs(); req = 3'b111;
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    req = 3'b000; rst = 1'b0;

    // 1: single read by the solver.
    tick(); t = cyc;
    req = 3'b010; ra[1] = 12'h005;
    push_rd(1, 12'h005, 32'hDEAD_BEEF, t);
    tick(); idle_inputs();
    repeat (5) tick();
    chk("t1_idle", 64'(idle), 64'h1);
    check_drained("t1");

    // 2: contention from reset, grants rotate 0,1,2,0,1,2.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      req = 3'b111;
      for (int i = 0; i < 3; i++) ra[i] = 12'(12'h010 * (i + 1) + cnt[i]);
      w = j % 3;
      push_rd(w, ra[w], pre(ra[w]), cyc);
      cnt[w]++;
    end
    tick(); idle_inputs();
    repeat (6) tick();
    check_drained("t2");

    // 3: mask 001 then 110; pending requester-0 reads still return to it.
    for (int j = 0; j < 3; j++) begin
      tick();
      phase_mask = 3'b001; req = 3'b111;
      ra[0] = 12'(12'h040 + j); ra[1] = 12'h050; ra[2] = 12'h060;
      push_rd(0, ra[0], pre(ra[0]), cyc);
    end
    tick(); phase_mask = 3'b110;
    push_rd(1, 12'h050, pre(12'h050), cyc);
    tick(); req = 3'b101;
    push_rd(2, 12'h060, pre(12'h060), cyc);
    tick(); idle_inputs(); phase_mask = 3'b111;
    repeat (6) tick();
    check_drained("t3");

    // 4: pusher writes then reads the same word back-to-back.
    tick(); t = cyc;
    req = 3'b100; req_we = 3'b100; ra[2] = 12'h0FF; rw[2] = 32'h0000_1234;
    push_wr(2, 12'h0FF, 32'h0000_1234, t);
    tick();
    req_we = 3'b000; rw[2] = 32'h0;
    push_rd(2, 12'h0FF, 32'h0000_1234, t + 1);
    tick(); idle_inputs();
    repeat (6) tick();
    check_drained("t4");

    // 5: three reads, then mask cleared; idle only after the last return.
    for (int j = 0; j < 3; j++) begin
      tick();
      req = 3'b010; ra[1] = 12'(12'h070 + j);
      push_rd(1, ra[1], pre(ra[1]), cyc);
    end
    tick(); phase_mask = 3'b000;
    for (int k = 3; k <= 7; k++) begin
      if (k > 3) tick();
      @(negedge clk);
      chk("t5_idle", 64'(idle), (k >= 6) ? 64'h1 : 64'h0);
    end
    tick(); idle_inputs(); phase_mask = 3'b111;
    repeat (2) tick();
    check_drained("t5");

    // 6: async reset with two reads in flight; pointer returns to 0.
    tick(); t = cyc;
    req = 3'b001; ra[0] = 12'h080;
    gq.push_back('{t, 3'b001, 1'b0, 12'h080, 32'h0});
    iq.push_back('{t + 1, 3'b001, 1'b0, 12'h080, 32'h0});
    tick();
    ra[0] = 12'h081;
    gq.push_back('{t + 1, 3'b001, 1'b0, 12'h081, 32'h0});
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_reset");
    tick(); tick();
    rst = 1'b0; req = 3'b111;
    ra[0] = 12'h090; ra[1] = 12'h091; ra[2] = 12'h092;
    push_rd(0, 12'h090, pre(12'h090), cyc);
    tick(); req = 3'b110;
    push_rd(1, 12'h091, pre(12'h091), cyc);
    tick(); idle_inputs();
    repeat (8) tick();
    check_drained("t6");
    chk("t6_idle", 64'(idle), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
